// File: rtl/btn_event_ctrl_if.sv
// Register bus between the CPU and the button event controller.
// The master drives address/strobes/data, and the slave returns registered read data.
interface btn_event_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write, writedata,
      output readdata
   );
endinterface

// File: rtl/btn_event_ctrl.sv
// Front-panel button controller: per-channel synchroniser, debounce/long-press FSM,
// an event capture register with W1C clearing, an irq mask, and a registered read port.
//
// state          | meaning
// S_RELEASED     | button idle, counter cleared
// S_PRESS_WAIT   | counting consecutive pressed samples toward debounce
// S_PRESSED      | debounced pressed, counting toward long-press
// S_HELD         | long-press reported, waiting for release
// S_RELEASE_WAIT | counting consecutive released samples toward debounce
module btn_event_ctrl #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic              clk,
   input  logic              reset,
   btn_event_ctrl_if.slave   bus,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_CYCLES);
   localparam bit DB_ONE = (DEBOUNCE_CYCLES <= 1);
   localparam logic [WIDTH-1:0] POL = {WIDTH{ACTIVE_LOW != 0}};

   localparam logic [2:0] S_RELEASED     = 3'd0;
   localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
   localparam logic [2:0] S_PRESSED      = 3'd2;
   localparam logic [2:0] S_HELD         = 3'd3;
   localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

   logic [WIDTH-1:0] sync1, sync2, pressed;
   logic [WIDTH-1:0] press_set, long_set, dbn;
   logic [WIDTH-1:0] ev_press, ev_long, mask_press, mask_long;
   logic [WIDTH-1:0] clr_press, clr_long;
   logic             wr_mask, wr_event;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   // Reset the synchroniser to the released pin level so reset exit never looks like a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= POL;
         sync2 <= POL;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   assign pressed = sync2 ^ POL;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [2:0]    st_q, st_d;
      logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
      logic          dbn_q, dbn_d, ps, ls;

      assign cnt_inc = cnt_q + CW'(1);

      always_comb begin
         st_d  = st_q;
         cnt_d = cnt_q;
         dbn_d = dbn_q;
         ps    = 1'b0;
         ls    = 1'b0;
         case (st_q)
            S_RELEASED: begin
               cnt_d = '0;
               if (pressed[i]) begin
                  if (DB_ONE) begin
                     st_d  = S_PRESSED;
                     dbn_d = 1'b1;
                     ps    = 1'b1;
                  end else begin
                     st_d = S_PRESS_WAIT;
                  end
               end
            end
            S_PRESS_WAIT: begin
               if (!pressed[i]) begin
                  st_d  = S_RELEASED;
                  cnt_d = '0;
               end else if (cnt_inc >= DB_LAST) begin
                  st_d  = S_PRESSED;
                  cnt_d = '0;
                  dbn_d = 1'b1;
                  ps    = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_PRESSED, S_HELD: begin
               if (!pressed[i]) begin
                  cnt_d = '0;
                  if (DB_ONE) begin
                     st_d  = S_RELEASED;
                     dbn_d = 1'b0;
                  end else begin
                     st_d = S_RELEASE_WAIT;
                  end
               end else if (st_q == S_PRESSED) begin
                  if (cnt_inc >= HOLD_CNT) begin
                     st_d  = S_HELD;
                     cnt_d = '0;
                     ls    = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            S_RELEASE_WAIT: begin
               // A re-press during release debounce resumes PRESSED silently with a fresh hold count.
               if (pressed[i]) begin
                  st_d  = S_PRESSED;
                  cnt_d = '0;
               end else if (cnt_inc >= DB_LAST) begin
                  st_d  = S_RELEASED;
                  cnt_d = '0;
                  dbn_d = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               st_d  = S_RELEASED;
               cnt_d = '0;
               dbn_d = 1'b0;
            end
         endcase
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            st_q  <= S_RELEASED;
            cnt_q <= '0;
            dbn_q <= 1'b0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            dbn_q <= dbn_d;
         end
      end

      assign press_set[i] = ps;
      assign long_set[i]  = ls;
      assign dbn[i]       = dbn_q;
   end

   assign wr_mask   = bus.chipselect & bus.write & (bus.address == 2'd1);
   assign wr_event  = bus.chipselect & bus.write & (bus.address == 2'd2);
   assign clr_press = wr_event ? bus.writedata[WIDTH-1:0] : '0;
   assign clr_long  = wr_event ? bus.writedata[16 +: WIDTH] : '0;
   assign unused_wdata = ^bus.writedata;

   // New events take priority over a W1C landing on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ev_press   <= '0;
         ev_long    <= '0;
         mask_press <= '0;
         mask_long  <= '0;
         irq        <= 1'b0;
      end else begin
         ev_press <= (ev_press & ~clr_press) | press_set;
         ev_long  <= (ev_long & ~clr_long) | long_set;
         if (wr_mask) begin
            mask_press <= bus.writedata[WIDTH-1:0];
            mask_long  <= bus.writedata[16 +: WIDTH];
         end
         irq <= |((ev_press & mask_press) | (ev_long & mask_long));
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         2'd0: rd_mux[WIDTH-1:0] = dbn;
         2'd1: begin
            rd_mux[WIDTH-1:0]  = mask_press;
            rd_mux[16 +: WIDTH] = mask_long;
         end
         2'd2: begin
            rd_mux[WIDTH-1:0]  = ev_press;
            rd_mux[16 +: WIDTH] = ev_long;
         end
         default: rd_mux[WIDTH-1:0] = pressed;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bus.readdata <= '0;
      else       bus.readdata <= rd_mux;
   end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: a register access table plus hand-written
// press, bounce, long-press, collision, reset and dual-channel sequences.
module tb_btn_event_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] in_port;
   logic       irq;

   btn_event_ctrl_if bus_if ();

   btn_event_ctrl #(
      .WIDTH(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16), .ACTIVE_LOW(1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_if),
      .in_port (in_port),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        do_write;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vecs[10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.write      = 1'b1;
      bus_if.writedata  = d;
      tick();
      bus_if.chipselect = 1'b0;
      bus_if.write      = 1'b0;
      bus_if.writedata  = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] got);
      bus_if.address = a;
      tick();
      got = bus_if.readdata;
   endtask

   task automatic release_and_clear();
      in_port = 2'b11;
      tick(10);
      wr(2'd2, 32'hFFFF_FFFF);
      tick();
   endtask

   initial begin
      logic [31:0] got;
      logic        irq_seen;
      logic        prev_irq;
      int          rises;

      // do_write, addr, wdata, expected readback
      vecs[0] = '{1'b0, 2'd0, 32'h0, 32'h0};
      vecs[1] = '{1'b0, 2'd1, 32'h0, 32'h0};
      vecs[2] = '{1'b0, 2'd2, 32'h0, 32'h0};
      vecs[3] = '{1'b0, 2'd3, 32'h0, 32'h0};
      vecs[4] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0003_0003};
      vecs[5] = '{1'b1, 2'd0, 32'h0000_FFFF, 32'h0};
      vecs[6] = '{1'b1, 2'd3, 32'h0000_000F, 32'h0};
      vecs[7] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
      vecs[8] = '{1'b1, 2'd1, 32'h0001_0002, 32'h0001_0002};
      vecs[9] = '{1'b1, 2'd1, 32'h0, 32'h0};

      reset             = 1'b1;
      in_port           = 2'b11;
      bus_if.address    = 2'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write      = 1'b0;
      bus_if.writedata  = '0;
      tick(3);
      check("reset_readdata", bus_if.readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].do_write) wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, got);
         check($sformatf("regvec%0d", i), got, vecs[i].exp);
      end
      check("regvec_irq", {31'b0, irq}, 32'h0);

      // Clean press on ch0: EVENT sets on the 6th edge and is visible through the read register one edge later, together with irq.
      wr(2'd1, 32'h1);
      bus_if.address = 2'd2;
      in_port = 2'b10;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("press_ev_k%0d", k), bus_if.readdata, (k >= 7) ? 32'h1 : 32'h0);
         check($sformatf("press_irq_k%0d", k), {31'b0, irq}, (k >= 7) ? 32'h1 : 32'h0);
      end
      rd(2'd0, got);
      check("press_state", got, 32'h1);
      wr(2'd2, 32'h1);
      check("w1c_irq_same_edge", {31'b0, irq}, 32'h1);
      tick();
      check("w1c_irq_next", {31'b0, irq}, 32'h0);
      rd(2'd2, got);
      check("w1c_event", got, 32'h0);
      in_port = 2'b11;
      tick(10);
      rd(2'd2, got);
      check("release_no_event", got, 32'h0);
      rd(2'd0, got);
      check("release_state", got, 32'h0);

      // Bounce on ch1: 3 pressed samples never reach a 4-sample debounce.
      wr(2'd1, 32'h0003_0003);
      irq_seen = 1'b0;
      for (int r = 0; r < 5; r++) begin
         in_port = 2'b01;
         for (int c = 0; c < 3; c++) begin
            tick();
            irq_seen |= irq;
         end
         in_port = 2'b11;
         tick();
         irq_seen |= irq;
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         irq_seen |= irq;
      end
      check("bounce_irq", {31'b0, irq_seen}, 32'h0);
      rd(2'd0, got);
      check("bounce_state", got, 32'h0);
      rd(2'd2, got);
      check("bounce_event", got, 32'h0);

      // Long press: only the long event is unmasked.
      wr(2'd1, 32'h0001_0000);
      bus_if.address = 2'd2;
      in_port = 2'b10;
      for (int k = 1; k <= 24; k++) begin
         tick();
         check($sformatf("long_ev_k%0d", k), bus_if.readdata,
               (k >= 23) ? 32'h0001_0001 : (k >= 7) ? 32'h1 : 32'h0);
         check($sformatf("long_irq_k%0d", k), {31'b0, irq}, (k >= 23) ? 32'h1 : 32'h0);
      end
      in_port = 2'b11;
      bus_if.address = 2'd0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("long_rel_state_k%0d", k), bus_if.readdata, (k >= 7) ? 32'h0 : 32'h1);
      end
      rd(2'd2, got);
      check("long_rel_no_new_event", got, 32'h0001_0001);
      wr(2'd1, 32'h0);
      check("mask_clr_irq_same_edge", {31'b0, irq}, 32'h1);
      tick();
      check("mask_clr_irq_next", {31'b0, irq}, 32'h0);
      release_and_clear();

      // W1C landing on the press-event edge: the set wins.
      in_port = 2'b10;
      tick(5);
      wr(2'd2, 32'h1);
      rd(2'd2, got);
      check("collision_event", got, 32'h1);
      wr(2'd1, 32'h1);
      tick();
      check("collision_irq", {31'b0, irq}, 32'h1);
      in_port = 2'b11;
      tick(10);

      // Reset in PRESS_WAIT with an event pending and irq high.
      in_port = 2'b10;
      tick(4);
      bus_if.address = 2'd2;
      #2 reset = 1'b1;
      #1;
      check("rst_async_irq", {31'b0, irq}, 32'h0);
      check("rst_async_readdata", bus_if.readdata, 32'h0);
      tick(2);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("rst_redebounce_k%0d", k), bus_if.readdata, (k >= 7) ? 32'h1 : 32'h0);
         check($sformatf("rst_irq_k%0d", k), {31'b0, irq}, 32'h0);
      end
      rd(2'd1, got);
      check("rst_mask", got, 32'h0);
      release_and_clear();

      // Both channels at once: one combined event and a single irq rise.
      wr(2'd1, 32'h3);
      bus_if.address = 2'd3;
      in_port = 2'b00;
      rises = 0;
      prev_irq = irq;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (irq && !prev_irq) rises++;
         prev_irq = irq;
         if (k == 2) check("both_raw_k2", bus_if.readdata, 32'h0);
         if (k == 3) begin
            check("both_raw_k3", bus_if.readdata, 32'h3);
            bus_if.address = 2'd2;
         end
         if (k == 6) check("both_ev_k6", bus_if.readdata, 32'h0);
         if (k == 7) begin
            check("both_ev_k7", bus_if.readdata, 32'h3);
            check("both_irq_k7", {31'b0, irq}, 32'h1);
         end
      end
      check("both_irq_rises", rises, 32'd1);
      release_and_clear();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
